// File: rtl/mem_resp_queue_if.sv
// Request / cache-response / writeback bundle for the memory-stage response queue.
interface mem_resp_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int META_W = 8
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [OFF_W-1:0]  req_offset;
    logic [META_W-1:0] req_meta;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [META_W-1:0] resp_meta;
    logic              resp_load;
    logic              flush;
    logic [CNT_W-1:0]  pending_cnt;
    logic              spurious_err;

    modport master (
        output req_valid, req_load, req_size, req_sign, req_offset, req_meta,
        output mem_data_ok, mem_rdata, resp_ready, flush,
        input  req_ready, resp_valid, resp_data, resp_meta, resp_load,
        input  pending_cnt, spurious_err
    );

    modport slave (
        input  req_valid, req_load, req_size, req_sign, req_offset, req_meta,
        input  mem_data_ok, mem_rdata, resp_ready, flush,
        output req_ready, resp_valid, resp_data, resp_meta, resp_load,
        output pending_cnt, spurious_err
    );
endinterface

// File: rtl/mem_resp_queue.sv
// In-order load/store response queue: captures cache data in request order, aligns and
// extends it, and swallows late responses belonging to requests cancelled by a flush.
module mem_resp_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int META_W = 8
) (
    input  logic            clk,
    input  logic            resetn,
    mem_resp_queue_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0]  head_q, head_d, tail_q, tail_d, comp_q, comp_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic              spur_q, spur_d;

    logic [META_W-1:0] meta_q [DEPTH];
    logic [META_W-1:0] meta_d [DEPTH];
    logic              load_q [DEPTH];
    logic              load_d [DEPTH];
    logic [1:0]        size_q [DEPTH];
    logic [1:0]        size_d [DEPTH];
    logic              sign_q [DEPTH];
    logic              sign_d [DEPTH];
    logic [OFF_W-1:0]  off_q  [DEPTH];
    logic [OFF_W-1:0]  off_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [PTR_W-1:0]  head_idx, tail_idx, comp_idx;
    logic [CNT_W-1:0]  occ;
    logic              head_done, alloc, pop;

    function automatic logic [DATA_W-1:0] align_ext(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        size,
        input logic              sign,
        input logic [OFF_W-1:0]  off,
        input logic              load
    );
        logic [OFF_W-1:0]         base;
        logic [DATA_W-1:0]        shifted;
        logic signed [DATA_W-1:0] top;
        int                       nb;
        int                       k;
        nb = 8 << size;
        if (nb > DATA_W) nb = DATA_W;
        base    = off & ~OFF_W'((nb / 8) - 1);
        shifted = raw >> {base, 3'b000};
        k       = DATA_W - nb;
        top     = $signed(shifted << k);
        if (!load)     return '0;
        else if (sign) return DATA_W'(top >>> k);
        else           return (shifted << k) >> k;
    endfunction

    assign head_idx  = head_q[PTR_W-1:0];
    assign tail_idx  = tail_q[PTR_W-1:0];
    assign comp_idx  = comp_q[PTR_W-1:0];
    assign occ       = tail_q - head_q;
    assign head_done = done_q[head_idx];

    // Discards still owed by the cache count against capacity.
    assign bus.req_ready = resetn && !bus.flush &&
                           (({1'b0, occ} + {1'b0, discard_q}) < (CNT_W + 1)'(DEPTH));
    assign alloc = bus.req_valid && bus.req_ready;
    assign pop   = head_done && bus.resp_ready && !bus.flush;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        comp_d    = comp_q;
        discard_d = discard_q;
        done_d    = done_q;
        spur_d    = spur_q;
        meta_d    = meta_q;
        load_d    = load_q;
        size_d    = size_q;
        sign_d    = sign_q;
        off_d     = off_q;
        data_d    = data_q;

        if (alloc) begin
            meta_d[tail_idx] = bus.req_meta;
            load_d[tail_idx] = bus.req_load;
            size_d[tail_idx] = bus.req_size;
            sign_d[tail_idx] = bus.req_sign;
            off_d[tail_idx]  = bus.req_offset;
            done_d[tail_idx] = 1'b0;
            tail_d           = tail_q + CNT_W'(1);
        end

        if (bus.mem_data_ok) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CNT_W'(1);
            end else if (comp_q != tail_q) begin
                data_d[comp_idx] = align_ext(bus.mem_rdata, size_q[comp_idx], sign_q[comp_idx],
                                             off_q[comp_idx], load_q[comp_idx]);
                done_d[comp_idx] = 1'b1;
                comp_d           = comp_q + CNT_W'(1);
            end else begin
                spur_d = 1'b1;
            end
        end

        if (pop) begin
            done_d[head_idx] = 1'b0;
            head_d           = head_q + CNT_W'(1);
        end

        // Every still-incomplete entry leaves behind one response to swallow.
        if (bus.flush) begin
            discard_d = discard_d + (tail_q - comp_d);
            done_d    = '0;
            head_d    = tail_q;
            comp_d    = tail_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q    <= '0;
            tail_q    <= '0;
            comp_q    <= '0;
            discard_q <= '0;
            done_q    <= '0;
            spur_q    <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            comp_q    <= comp_d;
            discard_q <= discard_d;
            done_q    <= done_d;
            spur_q    <= spur_d;
        end
    end

    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        load_q <= load_d;
        size_q <= size_d;
        sign_q <= sign_d;
        off_q  <= off_d;
        data_q <= data_d;
    end

    assign bus.resp_valid   = head_done;
    assign bus.resp_data    = head_done ? data_q[head_idx] : '0;
    assign bus.resp_meta    = head_done ? meta_q[head_idx] : '0;
    assign bus.resp_load    = head_done ? load_q[head_idx] : 1'b0;
    assign bus.pending_cnt  = occ;
    assign bus.spurious_err = spur_q;
endmodule

// File: tb/tb_mem_resp_queue.sv
// Bench for mem_resp_queue: directed scenarios plus random traffic on a 32-bit instance
// against a queue-based reference model, and directed checks on a 64-bit instance.
module tb_mem_resp_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_resp_queue_if #(.DATA_W(32), .DEPTH(DEPTH), .META_W(8)) b32 ();
    mem_resp_queue_if #(.DATA_W(64), .DEPTH(DEPTH), .META_W(8)) b64 ();

    mem_resp_queue #(.DATA_W(32), .DEPTH(DEPTH), .META_W(8)) u_dut32 (
        .clk(clk), .resetn(resetn), .bus(b32)
    );
    mem_resp_queue #(.DATA_W(64), .DEPTH(DEPTH), .META_W(8)) u_dut64 (
        .clk(clk), .resetn(resetn), .bus(b64)
    );

    typedef struct {
        logic [7:0]  meta;
        logic        load;
        logic [1:0]  size;
        logic        sign;
        logic [1:0]  off;
        logic        done;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_disc;
    logic m_spur;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Select the naturally aligned field, then zero/sign extend to dw bits.
    function automatic logic [63:0] ref_align(input int dw, input logic [63:0] raw,
                                              input logic [1:0] size, input logic sign,
                                              input int off, input logic load);
        int          nbytes;
        int          base;
        logic [63:0] field;
        logic [63:0] mask;
        nbytes = 1 << size;
        if (nbytes > dw / 8) nbytes = dw / 8;
        base  = (off / nbytes) * nbytes;
        field = raw >> (8 * base);
        mask  = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        field = field & mask;
        if (sign && field[8 * nbytes - 1]) field = field | ~mask;
        if (dw == 32) field = field & 64'h0000_0000_FFFF_FFFF;
        if (!load) field = 64'd0;
        return field;
    endfunction

    task automatic idle_inputs();
        b32.req_valid = 0; b32.req_load = 0; b32.req_size = 0; b32.req_sign = 0;
        b32.req_offset = 0; b32.req_meta = 0; b32.mem_data_ok = 0; b32.mem_rdata = 0;
        b32.resp_ready = 0; b32.flush = 0;
        b64.req_valid = 0; b64.req_load = 0; b64.req_size = 0; b64.req_sign = 0;
        b64.req_offset = 0; b64.req_meta = 0; b64.mem_data_ok = 0; b64.mem_rdata = 0;
        b64.resp_ready = 0; b64.flush = 0;
    endtask

    task automatic cycle32(input logic rv, input logic ld, input logic [1:0] sz,
                           input logic sg, input logic [1:0] off, input logic [7:0] meta,
                           input logic dok, input logic [31:0] rd, input logic rr,
                           input logic fl);
        logic        mv;
        logic        exp_rdy;
        int          idx;
        int          inc;
        logic [63:0] al;
        ent_t        e;
        mv = (mq.size() > 0) && mq[0].done;
        check("resp_valid", b32.resp_valid, mv);
        if (mv) begin
            check("resp_data", b32.resp_data, mq[0].data);
            check("resp_meta", b32.resp_meta, mq[0].meta);
            check("resp_load", b32.resp_load, mq[0].load);
        end
        check("pending_cnt", b32.pending_cnt, mq.size());
        check("spurious_err", b32.spurious_err, m_spur);

        b32.req_valid = rv; b32.req_load = ld; b32.req_size = sz; b32.req_sign = sg;
        b32.req_offset = off; b32.req_meta = meta; b32.mem_data_ok = dok;
        b32.mem_rdata = rd; b32.resp_ready = rr; b32.flush = fl;
        #1;
        exp_rdy = !fl && (mq.size() + m_disc < DEPTH);
        check("req_ready", b32.req_ready, exp_rdy);

        if (dok) begin
            if (m_disc > 0) begin
                m_disc--;
            end else begin
                idx = -1;
                foreach (mq[i]) if (!mq[i].done && idx < 0) idx = i;
                if (idx >= 0) begin
                    al = ref_align(32, {32'd0, rd}, mq[idx].size, mq[idx].sign,
                                   int'(mq[idx].off), mq[idx].load);
                    mq[idx].data = al[31:0];
                    mq[idx].done = 1'b1;
                end else begin
                    m_spur = 1'b1;
                end
            end
        end
        if (mv && rr && !fl) void'(mq.pop_front());
        if (rv && exp_rdy) begin
            e.meta = meta; e.load = ld; e.size = sz; e.sign = sg; e.off = off;
            e.done = 1'b0; e.data = 32'd0;
            mq.push_back(e);
        end
        if (fl) begin
            inc = 0;
            foreach (mq[i]) if (!mq[i].done) inc++;
            m_disc += inc;
            mq.delete();
        end
        @(negedge clk);
        idle_inputs();
        #1;
    endtask

    task automatic ld32(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                        input logic [7:0] meta, input logic rr);
        cycle32(1, 1, sz, sg, off, meta, 0, 32'd0, rr, 0);
    endtask

    task automatic dok32(input logic [31:0] d, input logic rr);
        cycle32(0, 0, 2'd0, 0, 2'd0, 8'd0, 1, d, rr, 0);
    endtask

    task automatic idle32(input logic rr, input logic fl);
        cycle32(0, 0, 2'd0, 0, 2'd0, 8'd0, 0, 32'd0, rr, fl);
    endtask

    task automatic step64(input logic rv, input logic [1:0] sz, input logic sg,
                          input logic [2:0] off, input logic [7:0] meta, input logic dok,
                          input logic [63:0] rd, input logic rr);
        b64.req_valid = rv; b64.req_load = 1'b1; b64.req_size = sz; b64.req_sign = sg;
        b64.req_offset = off; b64.req_meta = meta; b64.mem_data_ok = dok;
        b64.mem_rdata = rd; b64.resp_ready = rr;
        @(negedge clk);
        idle_inputs();
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        b32.req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", b32.req_ready, 1'b0);
        check("rst_resp_valid", b32.resp_valid, 1'b0);
        check("rst_resp_data", b32.resp_data, 32'd0);
        check("rst_resp_meta", b32.resp_meta, 8'd0);
        check("rst_resp_load", b32.resp_load, 1'b0);
        check("rst_pending", b32.pending_cnt, 3'd0);
        check("rst_spur", b32.spurious_err, 1'b0);
        check("rst64_valid", b64.resp_valid, 1'b0);
        check("rst64_spur", b64.spurious_err, 1'b0);
        resetn = 1'b1;
        idle_inputs();
        mq.delete();
        m_disc = 0;
        m_spur = 1'b0;
        @(negedge clk);
        #1;
    endtask

    logic [31:0] pat [4];

    initial begin
        resetn = 1'b0;
        idle_inputs();
        do_reset();

        // Byte load at offset 3, signed then unsigned.
        ld32(2'd0, 1, 2'd3, 8'h11, 0);
        dok32(32'h8012_3456, 0);
        check("sx_valid", b32.resp_valid, 1'b1);
        check("sx_data", b32.resp_data, 32'hFFFF_FF80);
        check("sx_meta", b32.resp_meta, 8'h11);
        idle32(1, 0);
        ld32(2'd0, 0, 2'd3, 8'h12, 0);
        dok32(32'h8012_3456, 0);
        check("zx_data", b32.resp_data, 32'h0000_0080);
        idle32(1, 0);

        // Fill all four entries, then drain in order.
        for (int k = 1; k <= 4; k++) ld32(2'd2, 0, 2'd0, 8'(k), 0);
        check("full_ready", b32.req_ready, 1'b0);
        check("full_pending", b32.pending_cnt, 3'd4);
        pat[0] = 32'hA000_000A; pat[1] = 32'hB000_000B;
        pat[2] = 32'hC000_000C; pat[3] = 32'hD000_000D;
        for (int k = 0; k < 4; k++) begin
            dok32(pat[k], 1);
            check("ord_meta", b32.resp_meta, 8'(k + 1));
            check("ord_data", b32.resp_data, pat[k]);
            if (k == 0) check("ready_before_pop", b32.req_ready, 1'b0);
            if (k == 1) check("ready_after_pop", b32.req_ready, 1'b1);
        end
        idle32(1, 0);

        // Backpressure on two completed entries.
        ld32(2'd2, 0, 2'd0, 8'h31, 0);
        ld32(2'd2, 0, 2'd0, 8'h32, 0);
        dok32(32'hAAAA_0001, 0);
        dok32(32'hBBBB_0002, 0);
        for (int k = 0; k < 5; k++) begin
            idle32(0, 0);
            check("bp_data", b32.resp_data, 32'hAAAA_0001);
            check("bp_meta", b32.resp_meta, 8'h31);
        end
        idle32(1, 0);
        check("bp_next_meta", b32.resp_meta, 8'h32);
        check("bp_next_data", b32.resp_data, 32'hBBBB_0002);
        idle32(1, 0);

        // Flush with three issued, one completed: two late responses are swallowed.
        for (int k = 5; k <= 7; k++) ld32(2'd2, 0, 2'd0, 8'(k), 0);
        dok32(32'h0000_0055, 0);
        idle32(0, 1);
        check("fl_pending", b32.pending_cnt, 3'd0);
        check("fl_valid", b32.resp_valid, 1'b0);
        check("fl_ready", b32.req_ready, 1'b1);
        ld32(2'd2, 0, 2'd0, 8'h09, 0);
        dok32(32'h1111_1111, 0);
        check("fl_drop_x", b32.resp_valid, 1'b0);
        dok32(32'h2222_2222, 0);
        check("fl_drop_y", b32.resp_valid, 1'b0);
        dok32(32'h3333_3333, 0);
        check("fl_z_valid", b32.resp_valid, 1'b1);
        check("fl_z_meta", b32.resp_meta, 8'h09);
        check("fl_z_data", b32.resp_data, 32'h3333_3333);
        idle32(1, 0);

        // Flush coincident with data_ok and two incomplete entries.
        ld32(2'd2, 0, 2'd0, 8'h21, 0);
        ld32(2'd2, 0, 2'd0, 8'h22, 0);
        cycle32(0, 0, 2'd0, 0, 2'd0, 8'd0, 1, 32'h0000_DEAD, 0, 1);
        ld32(2'd2, 0, 2'd0, 8'h23, 0);
        dok32(32'h4444_4444, 0);
        check("flok_drop", b32.resp_valid, 1'b0);
        dok32(32'h5555_5555, 0);
        check("flok_meta", b32.resp_meta, 8'h23);
        check("flok_data", b32.resp_data, 32'h5555_5555);
        idle32(1, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle32(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 8'($urandom),
                    ($urandom_range(0, 9) < 4), $urandom,
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
        end

        // 64-bit instance.
        step64(1, 2'd3, 0, 3'd0, 8'h41, 0, 64'd0, 0);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 1, 64'h0123_4567_89AB_CDEF, 0);
        check("d64_valid", b64.resp_valid, 1'b1);
        check("d64_ld_d", b64.resp_data, 64'h0123_4567_89AB_CDEF);
        check("d64_meta", b64.resp_meta, 8'h41);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 0, 64'd0, 1);
        check("d64_popped", b64.resp_valid, 1'b0);
        step64(1, 2'd2, 0, 3'd4, 8'h42, 0, 64'd0, 0);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 1, 64'hF000_0001_0000_0002, 0);
        check("d64_ld_wu", b64.resp_data, 64'h0000_0000_F000_0001);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 0, 64'd0, 1);
        step64(1, 2'd2, 1, 3'd5, 8'h43, 0, 64'd0, 0);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 1, 64'hF000_0001_0000_0002, 0);
        check("d64_ld_w", b64.resp_data, 64'hFFFF_FFFF_F000_0001);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 0, 64'd0, 1);
        check("d64_spur_pre", b64.spurious_err, 1'b0);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 1, 64'h1234, 0);
        check("d64_spur_set", b64.spurious_err, 1'b1);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 0, 64'd0, 0);
        step64(0, 2'd0, 0, 3'd0, 8'h00, 0, 64'd0, 0);
        check("d64_spur_hold", b64.spurious_err, 1'b1);
        check("d64_spur_empty", b64.pending_cnt, 3'd0);

        // Spurious on the 32-bit instance after a clean reset, then cleared by reset.
        do_reset();
        dok32(32'hCAFE_F00D, 0);
        check("spur32_set", b32.spurious_err, 1'b1);
        idle32(0, 0);
        idle32(0, 0);
        check("spur32_hold", b32.spurious_err, 1'b1);
        do_reset();
        check("spur32_clr", b32.spurious_err, 1'b0);
        check("spur64_clr", b64.spurious_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_resp_queue.md
Name: mem_resp_queue

Overview:
In-order load/store response queue for the memory stage. It allows up to DEPTH outstanding data-cache requests instead of the single-entry read buffer used today. Each entry captures rdata on data_ok, then aligns and sign/zero-extends it at a parametrised data width. On a pipeline flush, the block absorbs late responses for cancelled requests so they never reach writeback.

Parameters:
DATA_W, 32, data bus width; 32 or 64.
DEPTH, 4, outstanding request entries; power of two, >=2.
META_W, 8, opaque per-request payload (dest, pc index, etc.) returned with the response.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  1  new memory request issued to cache this cycle
req_ready  out  1  queue can accept a request
req_load  in  1  1=load (returns data), 0=store (returns 0)
req_size  in  2  00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
req_sign  in  1  sign-extend loaded value
req_offset  in  OFF_W  byte offset in bus word; OFF_W=log2(DATA_W/8)
req_meta  in  META_W  payload
mem_data_ok  in  1  cache returns one response, in request order
mem_rdata  in  DATA_W  raw read data, valid with mem_data_ok
resp_valid  out  1  head entry complete
resp_ready  in  1  writeback accepts head
resp_data  out  DATA_W  aligned/extended result
resp_meta  out  META_W  payload of head
resp_load  out  1  head is a load
flush  in  1  cancel all queued requests
pending_cnt  out  log2(DEPTH)+1  occupied entries
spurious_err  out  1  sticky: data_ok with nothing outstanding

Behaviour:
- Reset (resetn=0 at clk edge): head/tail/completion pointers=0, occupancy=0, discard_cnt=0, all done bits=0, spurious_err=0. resp_valid=0, resp_data=0, resp_meta=0, resp_load=0, pending_cnt=0. req_ready=0 while resetn=0.
- Circular FIFO of DEPTH entries; fields: meta, load, size, sign, offset, done, data.
- req_ready = resetn && !flush && (occupancy + discard_cnt < DEPTH). This bounds total in-flight cache responses to DEPTH.
- Allocate at tail on req_valid && req_ready.
- Completion pointer tracks the oldest allocated entry with done=0.
- On mem_data_ok:
  - if discard_cnt>0, decrement discard_cnt and drop the data;
  - else if an incomplete entry exists, write mem_rdata into it and set done;
  - else set spurious_err and ignore the data.
- Latency: the entry completed at edge N gives resp_valid=1 during cycle N+1. There is no combinational data_ok-to-resp path.
- resp_valid = head entry done (registered outputs). Pop on resp_valid && resp_ready.
- Allocate, complete and pop may all occur in the same cycle; occupancy is updated by +alloc -pop.
- Holding resp_ready low keeps resp_valid and all resp_* fields stable. Completions of younger entries continue while the head is held.
- Alignment: take the field at byte offset req_offset of size 1/2/4/8 bytes. Zero- or sign-extend it to DATA_W per sign. Size 10 with DATA_W=32 returns the full word. Offset low bits below size alignment are ignored (treated as 0). Stores return resp_data=0.
- Flush, evaluated at the clk edge:
  - all entries are invalidated; pointers are equalised and occupancy=0;
  - discard_cnt_next = discard_cnt + incomplete_entries - (mem_data_ok ? 1 : 0);
  - a data_ok in the flush cycle consumes one discard, or one incomplete entry if discard_cnt=0;
  - completed-but-unpopped entries are dropped with no discard;
  - a pop in the flush cycle is not performed; resp_valid=0 next cycle.
- pending_cnt = occupancy, excluding discards.

Test Plan:
- DATA_W=32. Single load: size 00, sign 1, offset 3; data_ok with rdata 32'h8012_3456 -> one cycle later resp_valid=1, resp_data=32'hFFFF_FF80, meta echoed. Same stimulus with sign=0 -> 32'h0000_0080.
- DEPTH=4. Four back-to-back loads (meta 1..4) -> req_ready=0 after the 4th, pending_cnt=4. Four data_ok with rdata A,B,C,D, resp_ready=1 -> responses meta 1..4 carry A..D in order. req_ready returns the cycle after the first pop.
- Backpressure: resp_ready=0 for 5 cycles with 2 completed entries -> resp_data and resp_meta stable. Releasing resp_ready pops one per cycle.
- Flush with 3 issued, 1 completed -> next cycle pending_cnt=0, discard_cnt=2, req_ready=1 (0+2<4). Then issue a new load (meta 9) and send three data_ok X,Y,Z -> X and Y dropped, meta 9 receives Z.
- Flush coincident with data_ok, 2 incomplete -> discard_cnt=1. Exactly one later data_ok is dropped.
- DATA_W=64: ld.d offset 0 -> full rdata; ld.wu offset 4, rdata 64'hF000_0001_0000_0002 -> 64'h0000_0000_F000_0001. Also data_ok with queue empty and discard 0 -> spurious_err=1, held until reset.
